// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: credit-limited requests to a variable-latency instruction
// memory, an in-order prefetch queue feeding IF/ID, and stale-response dropping on redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] Branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFtoID_PC,
  output logic [31:0] IFtoID_inst,
  output logic        IFtoID_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = CW + 4;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [CW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [31:0] q_pc4_q  [DEPTH];
  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] tag_q    [DEPTH];

  logic        credit_ok, grant, drop_rsp, accept_rsp, push, pop;
  logic [CW:0] in_use;

  // Credits cover queued entries plus in-flight requests, so an accepted response always fits.
  assign in_use     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign credit_ok  = in_use < (CW + 1)'(DEPTH);
  assign imem_req   = rst & ~PCSrc & credit_ok;
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req & imem_gnt;
  assign drop_rsp   = imem_rvalid & (drop_q != '0);
  assign accept_rsp = imem_rvalid & (drop_q == '0) & (outstanding_q != '0);
  assign push       = accept_rsp & ~PCSrc;

  assign IFtoID_valid = (count_q != '0);
  assign pop          = PCWrite & IFtoID_valid & ~PCSrc;
  assign IFtoID_PC    = IFtoID_valid ? q_pc4_q[rd_ptr_q[PW-1:0]]  : 32'h0;
  assign IFtoID_inst  = IFtoID_valid ? q_inst_q[rd_ptr_q[PW-1:0]] : 32'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (PCSrc) begin
      // Everything still in flight after this edge becomes a response to discard.
      fetch_pc_d    = Branch;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      tag_wr_d      = '0;
      tag_rd_d      = '0;
      outstanding_d = '0;
      drop_d        = drop_q + DW'(outstanding_q) - DW'(drop_rsp | accept_rsp);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + CW'(1);
      end
      if (drop_rsp) begin
        drop_d = drop_q - DW'(1);
      end
      if (accept_rsp) begin
        wr_ptr_d = wr_ptr_q + CW'(1);
        tag_rd_d = tag_rd_q + CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
      count_d       = count_q + CW'(accept_rsp) - CW'(pop);
      outstanding_d = outstanding_q + CW'(grant) - CW'(accept_rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Storage needs no reset: entries are only read while the queue or tag FIFO holds them.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      q_pc4_q[wr_ptr_q[PW-1:0]]  <= tag_q[tag_rd_q[PW-1:0]] + 32'd4;
      q_inst_q[wr_ptr_q[PW-1:0]] <= imem_rdata;
    end
    if (grant) begin
      tag_q[tag_wr_q[PW-1:0]] <= fetch_pc_q;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: table-driven reset/startup vectors, directed corner sequences,
// and randomized traffic checked against an in-order program-stream reference model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst, PCWrite, PCSrc, imem_gnt, imem_rvalid;
  logic [31:0] Branch, imem_rdata;
  logic        imem_req, IFtoID_valid;
  logic [31:0] imem_addr, IFtoID_PC, IFtoID_inst;

  inst_fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IFtoID_PC(IFtoID_PC), .IFtoID_inst(IFtoID_inst), .IFtoID_valid(IFtoID_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;
  mreq_t mq[$];

  int          checks = 0, errors = 0, cyc = 0, pops = 0;
  int unsigned lat = 1;
  logic [31:0] exp_pc = RPC;
  logic        last_valid, last_req, prev_stall;
  logic [31:0] last_pc, last_inst, last_addr, prev_addr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock cycle: drive inputs, emulate memory, sample outputs, advance the reference stream.
  task automatic cycle(input logic r, input logic pcw, input logic pcs,
                       input logic [31:0] br, input logic g);
    logic rv;
    @(negedge clk);
    rst = r; PCWrite = pcw; PCSrc = pcs; Branch = br; imem_gnt = g;
    rv = r && (mq.size() > 0) && (mq[0].due <= 32'(cyc));
    imem_rvalid = rv;
    imem_rdata  = rv ? (mq[0].addr ^ KEY) : $urandom;
    #1;
    last_valid = IFtoID_valid; last_pc = IFtoID_PC; last_inst = IFtoID_inst;
    last_req = imem_req; last_addr = imem_addr;
    if (!r || pcs) chk("req_blocked", {31'b0, imem_req}, 32'd0);
    if (!IFtoID_valid) begin
      chk("empty_inst", IFtoID_inst, 32'h0);
      chk("empty_pc", IFtoID_PC, 32'h0);
    end else begin
      chk("pair_match", IFtoID_inst, (IFtoID_PC - 32'd4) ^ KEY);
    end
    if (r && prev_stall) chk("addr_stable", imem_addr, prev_addr);
    prev_stall = r && imem_req && !g && !pcs;
    prev_addr  = imem_addr;
    if (r && pcw && IFtoID_valid && !pcs) begin
      chk("stream_pc", IFtoID_PC, exp_pc + 32'd4);
      chk("stream_inst", IFtoID_inst, exp_pc ^ KEY);
      $display("pop cycle=%0d pc4=%h inst=%h", cyc, IFtoID_PC, IFtoID_inst);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (!r) begin
      exp_pc = RPC;
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      if (pcs) exp_pc = br;
      if (imem_req && g) mq.push_back({imem_addr, 32'(cyc) + 32'(lat)});
    end
    cyc++;
  endtask

  typedef struct {
    logic        r;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] pc4;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] hp, hi, a0;
  logic        found;

  initial begin
    rst = 1'b0; PCWrite = 1'b0; PCSrc = 1'b0; Branch = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; prev_stall = 1'b0; prev_addr = '0;

    // Reset for two cycles, then zero-wait memory with IF/ID always consuming.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0040_0000, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0040_0004, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0040_0008, 32'h0040_0004};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0040_000C, 32'h0040_0008};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h0040_000C};
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].r, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("vec_req", {31'b0, last_req}, {31'b0, vecs[i].req});
      chk("vec_valid", {31'b0, last_valid}, {31'b0, vecs[i].valid});
      if (vecs[i].r) chk("vec_addr", last_addr, vecs[i].addr);
      chk("vec_pc", last_pc, vecs[i].pc4);
      chk("vec_inst", last_inst, vecs[i].valid ? ((vecs[i].pc4 - 32'd4) ^ KEY) : 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("steady_valid", {31'b0, last_valid}, 32'd1);
    end

    // Stall: outputs hold, requests stop once the credits are used up.
    for (int s = 0; s < 6; s++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (s == 0) begin
        chk("stall_valid", {31'b0, last_valid}, 32'd1);
        hp = last_pc; hi = last_inst;
      end else begin
        chk("stall_hold_pc", last_pc, hp);
        chk("stall_hold_inst", last_inst, hi);
      end
      if (s >= 3) chk("stall_req_off", {31'b0, last_req}, 32'd0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Flush with requests in flight on a slow memory.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      found = (mq.size() >= 2);
    end
    chk("flush_setup", {31'b0, found}, 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      found = last_valid;
    end
    chk("flush_timeout", {31'b0, found}, 32'd1);
    chk("flush_first_pc", last_pc, 32'h0000_0104);

    // Flush, pop and response all in the same cycle.
    lat = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("simul_pre_valid", {31'b0, last_valid}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("simul_empty", {31'b0, last_valid}, 32'd0);
    chk("simul_addr", last_addr, 32'h0000_0200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      found = last_valid;
    end
    chk("simul_first_pc", last_pc, 32'h0000_0204);

    // Back-pressure: request held with a constant address until granted.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (i == 0) a0 = last_addr;
      chk("bp_req", {31'b0, last_req}, 32'd1);
      chk("bp_addr", last_addr, a0);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_grant_addr", last_addr, a0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_resume_addr", last_addr, a0 + 32'd4);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic against the program-stream model.
    pops = 0;
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(1, 4);
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 24) == 0), ($urandom & 32'hFFFF_FFFC),
            ($urandom_range(0, 3) != 0));
    end
    chk("random_progress", {31'b0, (pops > 50)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
